// File: rtl/mollusc_rf_pkg.sv
// rtl/mollusc_rf_pkg.sv - shared defaults and helpers for the scoreboarded register file
package mollusc_rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 16;
    localparam int CNT_W_DEF = 2;
    localparam int REG_ZERO  = 0;

    function automatic int aw_of(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one read port: operand source select (fwd/wb/array) and hazard stall
module rf_read_port
    import mollusc_rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int AW    = 4,
    parameter int NFWD  = 2,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [AW-1:0]     i_addr,
    input  logic [NFWD-1:0]   i_fwd_valid,
    input  logic [NFWD-1:0]   i_fwd_rdy,
    input  logic [NFWD*AW-1:0]   i_fwd_addr,
    input  logic [NFWD*XLEN-1:0] i_fwd_data,
    input  logic              i_wb_valid,
    input  logic [AW-1:0]     i_wb_addr,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic [XLEN-1:0]   i_arr_data,
    input  logic [CNT_W-1:0]  i_pend,
    output logic [XLEN-1:0]   o_data,
    output logic              o_stall
);

    logic            w_zero;
    logic            w_fwd_hit;
    logic            w_fwd_rdy;
    logic [XLEN-1:0] w_fwd_data;
    logic            w_wb_hit;
    int              w_src_cnt;

    assign w_zero = (i_addr == AW'(REG_ZERO));

    // Scan oldest to youngest so the youngest matching stage is the one left selected.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_rdy  = 1'b0;
        w_fwd_data = '0;
        w_src_cnt  = 0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (i_fwd_valid[k] && (i_fwd_addr[k*AW +: AW] == i_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_rdy  = i_fwd_rdy[k];
                w_fwd_data = i_fwd_data[k*XLEN +: XLEN];
                w_src_cnt  = w_src_cnt + 1;
            end
        end
        w_wb_hit = i_wb_valid && (i_wb_addr == i_addr);
        if (w_wb_hit) begin
            w_src_cnt = w_src_cnt + 1;
        end
    end

    always_comb begin
        o_data = i_arr_data;
        if (i_rst || w_zero) begin
            o_data = '0;
        end else if (w_fwd_hit) begin
            o_data = w_fwd_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

    assign o_stall = !i_rst && i_en && !w_zero && (i_pend != '0) &&
                     ((w_src_cnt < int'(i_pend)) || (w_fwd_hit && !w_fwd_rdy));

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with pending-write scoreboard; RF_STALL_STATS_EN adds stall counters
module regfile_scoreboard
    import mollusc_rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NREAD = 4,
    parameter int NFWD  = 2,
    parameter int CNT_W = CNT_W_DEF,
    localparam int AW   = aw_of(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_addr,
    output logic                  iss_ready,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD-1:0]       fwd_rdy,
    input  logic [NFWD*AW-1:0]    fwd_addr,
    input  logic [NFWD*XLEN-1:0]  fwd_data,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic [NREAD-1:0]      rd_en,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_stall,
    output logic                  stall,
`ifdef RF_STALL_STATS_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           hazard_events,
`endif
    output logic                  err_sticky
);

    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
    localparam logic [AW-1:0]    ZERO     = AW'(REG_ZERO);

    logic [XLEN-1:0]  r_mem  [NREGS];
    logic [CNT_W-1:0] r_pend [NREGS];
    logic             r_err;

    logic w_wb_fire;
    logic w_iss_fire;
    logic w_iss_dec;
    logic w_underflow;

    assign w_wb_fire  = wb_valid && (wb_addr != ZERO);
    assign w_iss_dec  = w_wb_fire && (wb_addr == iss_addr);
    assign iss_ready  = !rst && ((iss_addr == ZERO) || (r_pend[iss_addr] != PEND_MAX) || w_iss_dec);
    assign w_iss_fire = iss_valid && iss_ready && (iss_addr != ZERO);
    // A writeback paired with a same-cycle issue of that register is balanced, not an underflow.
    assign w_underflow = w_wb_fire && (r_pend[wb_addr] == '0) &&
                         !(w_iss_fire && (iss_addr == wb_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i]  <= '0;
                r_pend[i] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            if (w_wb_fire) begin
                r_mem[wb_addr] <= wb_data;
            end
            for (int i = 1; i < NREGS; i++) begin
                logic inc, dec;
                inc = w_iss_fire && (iss_addr == AW'(i));
                dec = w_wb_fire && (wb_addr == AW'(i)) && ((r_pend[i] != '0) || inc);
                if (inc && !dec) begin
                    r_pend[i] <= r_pend[i] + CNT_W'(1);
                end else if (dec && !inc) begin
                    r_pend[i] <= r_pend[i] - CNT_W'(1);
                end
            end
            r_err <= r_err || w_underflow;
        end
    end

    assign err_sticky = r_err;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [AW-1:0] w_addr;
        assign w_addr = rd_addr[p*AW +: AW];

        rf_read_port #(
            .XLEN  (XLEN),
            .AW    (AW),
            .NFWD  (NFWD),
            .CNT_W (CNT_W)
        ) u_port (
            .i_rst       (rst),
            .i_en        (rd_en[p]),
            .i_addr      (w_addr),
            .i_fwd_valid (fwd_valid),
            .i_fwd_rdy   (fwd_rdy),
            .i_fwd_addr  (fwd_addr),
            .i_fwd_data  (fwd_data),
            .i_wb_valid  (wb_valid),
            .i_wb_addr   (wb_addr),
            .i_wb_data   (wb_data),
            .i_arr_data  (r_mem[w_addr]),
            .i_pend      (r_pend[w_addr]),
            .o_data      (rd_data[p*XLEN +: XLEN]),
            .o_stall     (rd_stall[p])
        );
    end

    assign stall = |rd_stall;

`ifdef RF_STALL_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_hazard_events;
    logic        r_stall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles  <= '0;
            r_hazard_events <= '0;
            r_stall_d       <= 1'b0;
        end else begin
            r_stall_d <= stall;
            if (stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (stall && !r_stall_d) begin
                r_hazard_events <= r_hazard_events + 32'd1;
            end
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign hazard_events = r_hazard_events;
`endif

endmodule
